// File: rtl/bus_pkg.sv
// Shared definitions for the bus initiator: default bus widths and the
// transaction state encoding.
package bus_pkg;

  localparam int AW_DEFAULT = 16;
  localparam int DW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding bus initiator: accepts one command, issues a one-cycle
// bus strobe, collects read data after RD_LAT cycles and holds the response.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int DW     = DW_DEFAULT,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_wr,
  output logic [AW-1:0] baddr,
  output logic [DW-1:0] bwrdata,
  output logic          bwr,
  output logic          bstrobe,
  input  logic [DW-1:0] brddata,
  output logic          busy,
  output logic [15:0]   txn_count
);

  // WAIT is entered with RD_LAT-1 so that it lasts exactly RD_LAT cycles.
  localparam logic [3:0] WAIT_INIT = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic            ready_q;
  logic            bstrobe_d, bwr_d, rsp_valid_d, rsp_wr_d;
  logic [AW-1:0]   baddr_d;
  logic [DW-1:0]   bwrdata_d, rsp_rdata_d;
  logic [15:0]     txn_count_d;

  // ready_q keeps cmd_ready low until the first clock edge after reset release.
  assign cmd_ready = (state_q == IDLE) && ready_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    bstrobe_d   = 1'b0;
    bwr_d       = bwr;
    baddr_d     = baddr;
    bwrdata_d   = bwrdata;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_wr_d    = rsp_wr;
    txn_count_d = txn_count;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = STROBE;
          bstrobe_d = 1'b1;
          bwr_d     = cmd_wr;
          baddr_d   = cmd_addr;
          bwrdata_d = cmd_wdata;
        end
      end
      STROBE: begin
        // bwr still holds the captured command direction here.
        if (bwr) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_wr_d    = 1'b1;
        end else if (RD_LAT == 0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = brddata;
          rsp_wr_d    = 1'b0;
        end else begin
          state_d = WAIT;
          wait_d  = WAIT_INIT;
        end
      end
      WAIT: begin
        if (wait_q == 4'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = brddata;
          rsp_wr_d    = 1'b0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          bwr_d       = 1'b0;
          txn_count_d = txn_count + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wait_q    <= 4'd0;
      ready_q   <= 1'b0;
      bstrobe   <= 1'b0;
      bwr       <= 1'b0;
      baddr     <= '0;
      bwrdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_wr    <= 1'b0;
      txn_count <= 16'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ready_q   <= 1'b1;
      bstrobe   <= bstrobe_d;
      bwr       <= bwr_d;
      baddr     <= baddr_d;
      bwrdata   <= bwrdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_wr    <= rsp_wr_d;
      txn_count <= txn_count_d;
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed scenarios plus randomized traffic checked
// every cycle against a timestamp-based transaction model.
module tb_bus_initiator;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_wr, rsp_ready;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        cmd_ready, rsp_valid, rsp_wr, bwr, bstrobe, busy;
  logic [15:0] rsp_rdata, baddr, bwrdata, brddata, txn_count;

  logic        x_valid;
  logic [15:0] x_addr;
  logic        rdy0, rv0, rw0, bwr0, bs0, busy0;
  logic [15:0] rd0, ba0, bwd0, brd0, tc0;
  logic        rdy15, rv15, rw15, bwr15, bs15, busy15;
  logic [15:0] rd15, ba15, bwd15, brd15, tc15;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          cyc = 0;
  logic        preload_pulse = 1'b0;

  logic [15:0] resp_mem [0:255];
  logic        rd_pend;
  int          since;
  int          s15;

  logic [15:0] model_mem [0:255];
  logic        in_txn, rdy_ok, m_wr, exp_strobe, exp_rv;
  logic [15:0] m_addr, m_wdata, m_rdata, m_txn, last_addr, last_wdata;
  int          t_acc;

  always #5 clk = ~clk;

  bus_initiator #(.AW(16), .DW(16), .RD_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_wr(rsp_wr), .baddr(baddr), .bwrdata(bwrdata), .bwr(bwr),
    .bstrobe(bstrobe), .brddata(brddata), .busy(busy), .txn_count(txn_count)
  );

  bus_initiator #(.AW(16), .DW(16), .RD_LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(x_valid), .cmd_ready(rdy0),
    .cmd_wr(1'b0), .cmd_addr(x_addr), .cmd_wdata(16'h0000),
    .rsp_valid(rv0), .rsp_ready(1'b1), .rsp_rdata(rd0),
    .rsp_wr(rw0), .baddr(ba0), .bwrdata(bwd0), .bwr(bwr0),
    .bstrobe(bs0), .brddata(brd0), .busy(busy0), .txn_count(tc0)
  );

  bus_initiator #(.AW(16), .DW(16), .RD_LAT(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(x_valid), .cmd_ready(rdy15),
    .cmd_wr(1'b0), .cmd_addr(x_addr), .cmd_wdata(16'h0000),
    .rsp_valid(rv15), .rsp_ready(1'b1), .rsp_rdata(rd15),
    .rsp_wr(rw15), .baddr(ba15), .bwrdata(bwd15), .bwr(bwr15),
    .bstrobe(bs15), .brddata(brd15), .busy(busy15), .txn_count(tc15)
  );

  // Responders drive valid read data only in the cycle the initiator must sample it.
  assign brddata = ((LAT == 0) ? (bstrobe && !bwr) : (rd_pend && since == LAT))
                   ? resp_mem[baddr[7:0]] : ~resp_mem[baddr[7:0]];
  assign brd0  = bs0 ? (ba0 ^ 16'hA5A6) : 16'h0BAD;
  assign brd15 = (s15 == 15) ? (ba15 ^ 16'hA5A6) : 16'h0BAD;

  initial begin : responder
    for (int i = 0; i < 256; i++) resp_mem[i] = 16'(i) ^ 16'hA5A6;
    rd_pend = 1'b0;
    since   = 0;
    s15     = 0;
    forever begin
      @(posedge clk);
      if (bstrobe && bwr) resp_mem[baddr[7:0]] <= bwrdata;
      if (bstrobe && !bwr) begin
        rd_pend <= 1'b1;
        since   <= 1;
      end else if (rd_pend) begin
        since <= since + 1;
      end
      if (bs15) s15 <= 1;
      else if (s15 != 0) s15 <= s15 + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic rr);
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd_wr    = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    rsp_ready = rr;
  endtask

  // Model: one transaction tracked by its accept cycle; outputs follow from cycle offsets.
  initial begin : compare
    for (int i = 0; i < 256; i++) model_mem[i] = 16'(i) ^ 16'hA5A6;
    in_txn = 1'b0; rdy_ok = 1'b0; m_txn = 16'd0; t_acc = 0;
    last_addr = 16'd0; last_wdata = 16'd0;
    m_wr = 1'b0; m_addr = 16'd0; m_wdata = 16'd0; m_rdata = 16'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (preload_pulse) m_txn = 16'hFFFF;
      if (!rst_n) begin
        in_txn = 1'b0; rdy_ok = 1'b0; m_txn = 16'd0;
        last_addr = 16'd0; last_wdata = 16'd0;
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bstrobe", 32'(bstrobe), 32'd0);
        checkOutput("rst_bwr", 32'(bwr), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_wr", 32'(rsp_wr), 32'd0);
        checkOutput("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("rst_baddr", 32'(baddr), 32'd0);
        checkOutput("rst_bwrdata", 32'(bwrdata), 32'd0);
        checkOutput("rst_txn_count", 32'(txn_count), 32'd0);
      end else begin
        exp_strobe = in_txn && (cyc == t_acc + 1);
        if (exp_strobe) begin
          last_addr  = m_addr;
          last_wdata = m_wdata;
          if (m_wr) model_mem[m_addr[7:0]] = m_wdata;
        end
        exp_rv = in_txn && (cyc >= t_acc + (m_wr ? 2 : LAT + 2));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(rdy_ok && !in_txn));
        checkOutput("busy", 32'(busy), 32'(in_txn));
        checkOutput("bstrobe", 32'(bstrobe), 32'(exp_strobe));
        checkOutput("bwr", 32'(bwr), 32'(in_txn && m_wr && cyc > t_acc));
        checkOutput("baddr", 32'(baddr), 32'(last_addr));
        checkOutput("bwrdata", 32'(bwrdata), 32'(last_wdata));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        checkOutput("txn_count", 32'(txn_count), 32'(m_txn));
        if (exp_rv) begin
          checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
          checkOutput("rsp_wr", 32'(rsp_wr), 32'(m_wr));
        end
        if (rdy_ok && !in_txn && cmd_valid) begin
          in_txn  = 1'b1;
          t_acc   = cyc;
          m_wr    = cmd_wr;
          m_addr  = cmd_addr;
          m_wdata = cmd_wdata;
          m_rdata = cmd_wr ? 16'd0 : model_mem[cmd_addr[7:0]];
        end else if (exp_rv && rsp_ready) begin
          in_txn = 1'b0;
          m_txn  = m_txn + 16'd1;
        end
        rdy_ok = 1'b1;
      end
    end
  end

  initial begin : driver
    int first0, first15;
    logic [15:0] data0, data15;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'd0;
    cmd_wdata = 16'd0; rsp_ready = 1'b1; x_valid = 1'b0; x_addr = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("lit_reset_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("lit_release_cycle_ready", 32'(cmd_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_after_release_ready", 32'(cmd_ready), 32'd1);

    // Write 0x0012 <- 0xBEEF; cmd_* changes after accept must be ignored.
    applyStimulus(1'b1, 1'b1, 16'h0012, 16'hBEEF, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_wr_bstrobe", 32'(bstrobe), 32'd1);
    checkOutput("lit_wr_bwr", 32'(bwr), 32'd1);
    checkOutput("lit_wr_baddr", 32'(baddr), 32'h0012);
    checkOutput("lit_wr_bwrdata", 32'(bwrdata), 32'hBEEF);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_wr_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("lit_wr_rsp_rdata", 32'(rsp_rdata), 32'd0);
    checkOutput("lit_wr_strobe_gone", 32'(bstrobe), 32'd0);

    // Read 0x0003 with RD_LAT=1 returns 0xA5A5 at C+3.
    applyStimulus(1'b1, 1'b0, 16'h0003, 16'h1234, 1'b1);
    @(negedge clk);
    checkOutput("lit_txn_after_write", 32'(txn_count), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_rd_not_yet", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_rd_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("lit_rd_rsp_rdata", 32'(rsp_rdata), 32'hA5A5);
    checkOutput("lit_rd_rsp_wr", 32'(rsp_wr), 32'd0);

    // Backpressure with a competing command held on the input.
    applyStimulus(1'b1, 1'b1, 16'h0100, 16'h5555, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0);
      @(negedge clk);
      checkOutput("lit_bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("lit_bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_bp_ready_again", 32'(cmd_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_bp_second_strobe", 32'(bstrobe), 32'd1);
    checkOutput("lit_bp_second_addr", 32'(baddr), 32'h0200);
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Reset while the read sits in WAIT.
    applyStimulus(1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("lit_wait_rst_txn", 32'(txn_count), 32'd0);
    checkOutput("lit_wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_wait_rst_ready", 32'(cmd_ready), 32'd1);
    repeat (4) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

    // Counter wrap from a preloaded 0xFFFF.
    @(negedge clk);
    #1;
    force u_dut.txn_count = 16'hFFFF;
    preload_pulse = 1'b1;
    @(posedge clk); #1 release u_dut.txn_count;
    @(negedge clk);
    #1 preload_pulse = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h0020, 16'h0001, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    checkOutput("lit_wrap", 32'(txn_count), 32'd0);

    // Read latency of the RD_LAT=0 and RD_LAT=15 builds.
    first0 = -1; first15 = -1; data0 = 16'd0; data15 = 16'd0;
    @(posedge clk); #1 x_valid = 1'b1; x_addr = 16'h0040;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk); #1 x_valid = 1'b0;
      @(negedge clk);
      if (first0 < 0 && rv0) begin first0 = k; data0 = rd0; end
      if (first15 < 0 && rv15) begin first15 = k; data15 = rd15; end
    end
    checkOutput("lit_lat0_cycles", 32'(first0), 32'd2);
    checkOutput("lit_lat0_data", 32'(data0), 32'hA5E6);
    checkOutput("lit_lat15_cycles", 32'(first15), 32'd17);
    checkOutput("lit_lat15_data", 32'(data15), 32'hA5E6);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk); #3 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
      end else begin
        applyStimulus($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom), $urandom_range(0, 9) < 7);
      end
    end
    repeat (25) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
